systolic_feeder: RTL and testbench
==================================

SYSTOLIC_FEEDER -- requirements
Module: systolic_feeder

Interface
REQ-001 SHALL have parameter M, default 9: number of X elements per row (im2col output columns).
REQ-002 SHALL have parameter N, default 2: number of rows streamed (reduction depth).
REQ-003 SHALL have parameter K, default 1: number of W elements per row (filter count).
REQ-004 SHALL have parameter DATA_WIDTH, default 32: element width in bits.
REQ-005 SHALL have parameter ADDR_WIDTH, default 32: memory address width in bits.
REQ-006 SHALL have parameter IM2COL_BASE, default 32'h00002000: word address of X matrix, row-major, N rows of M words.
REQ-007 SHALL have parameter WEIGHT_BASE, default 32'h00001000: word address of W matrix, row-major, N rows of K words.
REQ-008 SHALL use one clock and a synchronous, active-low reset; ports: clk input 1 (rising-edge clock); rst_n input 1 (synchronous, active-low reset).
REQ-009 SHALL have start, input, 1 bit: request a load-and-stream run; sampled in IDLE only.
REQ-010 SHALL have addr_rd, output, ADDR_WIDTH bits: memory read word address.
REQ-011 SHALL have data_rd, input, DATA_WIDTH bits: memory read data, valid exactly one cycle after addr_rd.
REQ-012 SHALL have X, output, DATA_WIDTH*M bits: current X row; element j at bits [(j+1)*DATA_WIDTH-1 : j*DATA_WIDTH].
REQ-013 SHALL have W, output, DATA_WIDTH*K bits: current W row, packed like X.
REQ-014 SHALL have valid, output, 1 bit: X/W carry a live row this cycle.
REQ-015 SHALL have busy, output, 1 bit: high in any state other than IDLE.
REQ-016 SHALL have done, output, 1 bit: single-cycle pulse marking the end of a run.

Function
REQ-017 SHALL implement states IDLE, LOAD, STREAM, FINISH.
- IDLE->LOAD on start=1.
- LOAD->STREAM after the last read data is captured.
- STREAM->FINISH after N rows are presented.
- FINISH->IDLE unconditionally.
REQ-018 In LOAD, SHALL issue R = N*(M+K) reads, one per cycle, on consecutive cycles with no gaps; the first read SHALL be in the first LOAD cycle.
- Reads 0..N*M-1: addr_rd = IM2COL_BASE + i*M + j (i row-major outer, j inner).
- Then: addr_rd = WEIGHT_BASE + i*K + j.
REQ-019 SHALL capture data_rd one cycle after each address into the internal buffer slot (row i, element j) of that address; LOAD SHALL last R+1 cycles.
REQ-020 addr_rd SHALL be 0 in every state except LOAD.
REQ-021 In STREAM, row r (r = 0..N-1) SHALL be driven on X and W with valid=1 in the r-th STREAM cycle; STREAM SHALL last exactly N cycles.
REQ-022 In FINISH, the block SHALL assert done=1 for one cycle, drive X=0 and valid=0, and hold W at row N-1.
REQ-023 In IDLE, X SHALL be 0 and valid SHALL be 0; W SHALL keep its last value.
REQ-024 start SHALL be ignored while busy=1; start held high through FINISH SHALL begin a new run from the IDLE cycle that follows.
REQ-025 Cycle count from the cycle start is sampled to done inclusive SHALL be 1 + (R+1) + N + 1.
REQ-026 Data SHALL pass through unmodified; no arithmetic or sign handling.
REQ-027 Buffer contents SHALL be fully overwritten on each run; no data SHALL leak from a previous run.

Reset
REQ-028 With rst_n=0 at a rising edge, the block SHALL next be in IDLE with: X=0, W=0, valid=0, busy=0, done=0, addr_rd=0, and all counters 0.
REQ-029 Reset asserted in any state, including mid-LOAD or mid-STREAM, SHALL abort the run with no done pulse; the first start after reset is released SHALL begin a full run.

Verification
REQ-030 Defaults, memory X[i][j]=16*i+j and W[i][0]=100+i, start pulse:
- addr_rd sequence 0x2000..0x2011, then 0x1000, 0x1001 (20 reads).
- valid high for 2 cycles: row0 X elements 0..8 = 0..8, W=100; row1 X = 16..24, W=101.
- done 24 cycles after start.
REQ-031 start re-asserted during LOAD and during STREAM -> no restart; addr sequence and output rows identical to REQ-030; exactly one done pulse.
REQ-032 rst_n=0 for one cycle during the 3rd STREAM-bound read, then start:
- All outputs 0 the cycle after reset.
- No done pulse for the aborted run.
- The new run matches REQ-030 exactly.
REQ-033 Back-to-back runs with start held high, memory changed between runs -> the second run's rows reflect the new contents only; one IDLE cycle separates done from the second run's first read.
REQ-034 M=1, N=1, K=4 with W words 0xA,0xB,0xC,0xD:
- 5 reads.
- One valid cycle with W = {0xD,0xC,0xB,0xA} (element 0 in the LSBs).
- done 8 cycles after start.

Source files
------------

// File: rtl/systolic_feeder.sv
// Loads N rows of X (M words) and W (K words) from a 1-cycle-latency memory,
// then presents one row pair per cycle to a systolic array.
module systolic_feeder #(
  parameter int M          = 9,
  parameter int N          = 2,
  parameter int K          = 1,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] IM2COL_BASE = 32'h00002000,
  parameter logic [ADDR_WIDTH-1:0] WEIGHT_BASE = 32'h00001000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  output logic [ADDR_WIDTH-1:0]   addr_rd,
  input  logic [DATA_WIDTH-1:0]   data_rd,
  output logic [DATA_WIDTH*M-1:0] X,
  output logic [DATA_WIDTH*K-1:0] W,
  output logic                    valid,
  output logic                    busy,
  output logic                    done
);
  localparam int NM = N * M;
  localparam int R  = N * (M + K);
  localparam int CW = $clog2(R + 1);
  localparam int RW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, LOAD, STREAM, FINISH} state_t;

  state_t                         state;
  logic [CW-1:0]                  lcnt;
  logic [CW-1:0]                  lnext;
  logic [RW-1:0]                  row;
  // X rows occupy slots 0..NM-1, W rows follow; slot order equals read order
  logic [R-1:0][DATA_WIDTH-1:0]   mem;

  assign lnext = lcnt + CW'(1);

  // Both matrices are row-major and contiguous, so read i maps linearly.
  function automatic logic [ADDR_WIDTH-1:0] rd_addr(input logic [CW-1:0] idx);
    if (idx < CW'(NM)) return IM2COL_BASE + ADDR_WIDTH'(idx);
    return WEIGHT_BASE + ADDR_WIDTH'(idx - CW'(NM));
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      lcnt    <= '0;
      row     <= '0;
      addr_rd <= '0;
      mem     <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state   <= LOAD;
          lcnt    <= '0;
          addr_rd <= rd_addr(CW'(0));
        end
        LOAD: begin
          // lcnt counts LOAD cycles; data for read lcnt-1 is on the bus now
          for (int s = 0; s < R; s++)
            if (lcnt == CW'(s + 1)) mem[s] <= data_rd;
          if (lcnt == CW'(R)) begin
            state   <= STREAM;
            lcnt    <= '0;
            row     <= '0;
            addr_rd <= '0;
          end else begin
            lcnt    <= lnext;
            addr_rd <= (lnext < CW'(R)) ? rd_addr(lnext) : '0;
          end
        end
        STREAM: begin
          if (row == RW'(N - 1)) state <= FINISH;
          else                   row   <= row + RW'(1);
        end
        FINISH:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Row mux as an OR chain of one-hot terms; W follows row in every state so
  // it holds row N-1 after a run and reads zero after reset.
  logic [N:0][DATA_WIDTH*M-1:0] xacc;
  logic [N:0][DATA_WIDTH*K-1:0] wacc;
  assign xacc[0] = '0;
  assign wacc[0] = '0;

  for (genvar r = 0; r < N; r++) begin : g_row
    logic hit;
    assign hit        = (row == RW'(r));
    assign xacc[r+1]  = xacc[r] | ((hit && state == STREAM) ? mem[r*M +: M] : '0);
    assign wacc[r+1]  = wacc[r] | (hit ? mem[NM + r*K +: K] : '0);
  end

  assign X     = xacc[N];
  assign W     = wacc[N];
  assign valid = (state == STREAM);
  assign busy  = (state != IDLE);
  assign done  = (state == FINISH);
endmodule

// File: tb/tb_systolic_feeder.sv
// Bench for systolic_feeder: per-cycle timeline checks against a memory-array
// model, plus a small M=1,N=1,K=4 instance.
module tb_systolic_feeder;
  localparam int M = 9, N = 2, K = 1, DW = 32, AW = 32;
  localparam int R = N * (M + K), NM = N * M;
  localparam int LOGN = 4096;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, start, valid, busy, done;
  logic [AW-1:0] addr_rd;
  logic [DW-1:0] data_rd;
  logic [DW*M-1:0] X;
  logic [DW*K-1:0] W;

  logic          start2, valid2, busy2, done2;
  logic [AW-1:0] addr_rd2;
  logic [DW-1:0] data_rd2;
  logic [DW-1:0] X2;
  logic [4*DW-1:0] W2;

  systolic_feeder #(.M(M), .N(N), .K(K), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .addr_rd(addr_rd), .data_rd(data_rd),
    .X(X), .W(W), .valid(valid), .busy(busy), .done(done));

  systolic_feeder #(.M(1), .N(1), .K(4), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .addr_rd(addr_rd2), .data_rd(data_rd2),
    .X(X2), .W(W2), .valid(valid2), .busy(busy2), .done(done2));

  logic [31:0] xm [N][M];
  logic [31:0] wm [N][K];
  logic [31:0] x2val;

  function automatic logic [31:0] lookup(input logic [31:0] a);
    int off;
    if (a >= 32'h2000 && a < 32'h2000 + NM) begin
      off = int'(a - 32'h2000);
      return xm[off / M][off % M];
    end
    if (a >= 32'h1000 && a < 32'h1000 + N*K) begin
      off = int'(a - 32'h1000);
      return wm[off / K][off % K];
    end
    return 32'hdead_beef;
  endfunction

  function automatic logic [31:0] lookup2(input logic [31:0] a);
    if (a == 32'h2000) return x2val;
    if (a >= 32'h1000 && a < 32'h1004) return 32'hA + (a - 32'h1000);
    return 32'hdead_beef;
  endfunction

  always @(posedge clk) begin
    data_rd  <= lookup(addr_rd);
    data_rd2 <= lookup2(addr_rd2);
  end

  // Reference: address i of the read sequence, and packed rows from the arrays
  function automatic logic [31:0] exp_addr(input int i);
    int j;
    if (i < NM) return 32'h2000 + (i / M) * M + (i % M);
    j = i - NM;
    return 32'h1000 + (j / K) * K + (j % K);
  endfunction

  function automatic logic [DW*M-1:0] exp_x(input int r);
    logic [DW*M-1:0] v;
    v = '0;
    for (int j = 0; j < M; j++) v[j*DW +: DW] = xm[r][j];
    return v;
  endfunction

  function automatic logic [DW*K-1:0] exp_w(input int r);
    logic [DW*K-1:0] v;
    v = '0;
    for (int j = 0; j < K; j++) v[j*DW +: DW] = wm[r][j];
    return v;
  endfunction

  int total = 0, bad = 0;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  // Per-cycle log of DUT outputs sampled at the falling edge
  logic [AW-1:0]   l_addr [LOGN];
  logic [DW*M-1:0] l_x    [LOGN];
  logic [DW*K-1:0] l_w    [LOGN];
  logic            l_v    [LOGN];
  logic            l_b    [LOGN];
  logic            l_d    [LOGN];
  int cyc = 0;

  task automatic tick();
    @(negedge clk);
    cyc++;
    if (cyc < LOGN) begin
      l_addr[cyc] = addr_rd;
      l_x[cyc]    = X;
      l_w[cyc]    = W;
      l_v[cyc]    = valid;
      l_b[cyc]    = busy;
      l_d[cyc]    = done;
    end
  endtask

  // Cycle o is the IDLE cycle in which start was sampled.
  task automatic check_run(input int o);
    int c, r;
    bit ev;
    for (int k = 1; k <= R + N + 3; k++) begin
      c = o + k;
      if (c >= LOGN) begin
        chk("log_overflow", 1, 0);
        return;
      end
      chk($sformatf("addr k%0d", k), l_addr[c], (k <= R) ? exp_addr(k - 1) : 32'h0);
      ev = (k >= R + 2) && (k <= R + N + 1);
      chk($sformatf("valid k%0d", k), l_v[c], ev);
      chk($sformatf("done k%0d", k), l_d[c], k == R + N + 2);
      chk($sformatf("busy k%0d", k), l_b[c], k <= R + N + 2);
      if (ev) begin
        r = k - R - 2;
        chk($sformatf("xrow%0d", r), l_x[c], exp_x(r));
        chk($sformatf("wrow%0d", r), l_w[c], exp_w(r));
      end else begin
        chk($sformatf("xzero k%0d", k), l_x[c], 0);
      end
      if (k >= R + N + 2) chk($sformatf("whold k%0d", k), l_w[c], exp_w(N - 1));
    end
  endtask

  // mode 0: pulse, 1: re-pokes in LOAD/STREAM, 2: random pokes, 3: hold start
  task automatic run(input int mode);
    int o;
    o = cyc;
    start = 1'b1;
    for (int k = 1; k <= R + N + 3; k++) begin
      tick();
      case (mode)
        1:       start = (k == 5) || (k == R + 2);
        2:       start = (k <= R + N + 2) ? 1'($urandom % 2) : 1'b0;
        3:       start = 1'b1;
        default: start = 1'b0;
      endcase
    end
    check_run(o);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_x"}, X, 0);
    chk({tag, "_w"}, W, 0);
    chk({tag, "_valid"}, valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_addr"}, addr_rd, 0);
  endtask

  task automatic abort_run(input int kr);
    bit seen;
    start = 1'b1;
    for (int k = 1; k <= kr; k++) begin
      tick();
      start = 1'b0;
    end
    rst_n = 1'b0;
    tick();
    chk_zero($sformatf("abort%0d", kr));
    rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < R + N + 4; k++) begin
      tick();
      if (done || busy) seen = 1'b1;
    end
    chk($sformatf("abort%0d_quiet", kr), seen, 0);
  endtask

  task automatic default_mem();
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < M; j++) xm[i][j] = 32'(16 * i + j);
      for (int j = 0; j < K; j++) wm[i][j] = 32'(100 + i);
    end
  endtask

  task automatic rand_mem();
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < M; j++) xm[i][j] = $urandom;
      for (int j = 0; j < K; j++) wm[i][j] = $urandom;
    end
  endtask

  task automatic run2();
    logic [31:0] ea [5];
    logic [4*DW-1:0] wv;
    logic [DW-1:0] xv;
    int nrd, nv, dk;
    ea = '{32'h2000, 32'h1000, 32'h1001, 32'h1002, 32'h1003};
    x2val = $urandom;
    nrd = 0; nv = 0; dk = -1; wv = '0; xv = '0;
    @(negedge clk);
    start2 = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      start2 = 1'b0;
      if (addr_rd2 != 0) begin
        if (nrd < 5) begin
          chk($sformatf("s_addr%0d", nrd), addr_rd2, ea[nrd]);
          chk($sformatf("s_rdcyc%0d", nrd), k, nrd + 1);
        end
        nrd++;
      end
      if (valid2) begin
        nv++;
        wv = W2;
        xv = X2;
      end
      if (done2 && dk < 0) dk = k;
    end
    chk("s_nreads", nrd, 5);
    chk("s_nvalid", nv, 1);
    chk("s_w", wv, {32'hD, 32'hC, 32'hB, 32'hA});
    chk("s_x", xv, x2val);
    chk("s_done_cyc", dk, 8);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; start2 = 1'b0; x2val = '0;
    default_mem();
    repeat (2) tick();
    chk_zero("reset");
    chk("reset_busy2", busy2, 0);
    rst_n = 1'b1;
    tick();

    run(0);
    run(1);
    abort_run(3);
    run(0);
    abort_run(R + 2);
    run(0);

    rand_mem();
    run(3);
    rand_mem();
    run(0);

    for (int n = 0; n < 6; n++) begin
      rand_mem();
      run(2);
      tick();
    end

    run2();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
